// File: rtl/phi_slice_hist_v2.sv
// Per-phi-slice eta histogram fill with a single-pass 3-bin cluster scan; PHI_SLICE_XCNT_EN adds special-track counts.
// Track to histogram 2 cycles, stop to first bin 3 cycles; scan index freezes while clu_valid && !clu_ready.
module phi_slice_hist_v2 #(
  parameter int PHIBIN = 0,
  parameter int NCH    = 2,
  parameter int NETA   = 24,
  parameter int PTW    = 9,
  parameter int NTW    = 5,
  parameter int NXW    = 4,
  parameter int PHIW   = 5,
  parameter int ETAW   = 5
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          start,
  input  logic                          stop,
  input  logic [NCH-1:0]                trk_valid,
  input  logic [NCH*PHIW-1:0]           trk_phi,
  input  logic [NCH*ETAW-1:0]           trk_eta,
  input  logic [NCH*PTW-1:0]            trk_pt,
  input  logic [NCH-1:0]                trk_bitx,
  output logic [NTW+NXW+ETAW+PTW-1:0]   clu_data,
  output logic                          clu_valid,
  input  logic                          clu_ready,
  output logic                          busy,
  output logic                          filled,
  output logic                          done,
  output logic                          ovf
);
  localparam int IW = $clog2(NETA + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, SCAN} state_t;

  state_t                    state;
  logic                      dcnt;
  logic [IW-1:0]             idx;
  logic [NETA-1:0]           cons;
  logic                      stall;

  logic [NCH-1:0]            acc;
  logic [NCH-1:0]            s1_vld;
  logic [NCH-1:0][ETAW-1:0]  s1_eta;
  logic [NCH-1:0][PTW-1:0]   s1_pt;

  logic [PTW-1:0]            h_pt [NETA];
  logic [NTW-1:0]            h_nt [NETA];
  logic [PTW-1:0]            n_pt [NETA];
  logic [NTW-1:0]            n_nt [NETA];
  logic [NETA-1:0]           bin_sat;
  logic [PTW+2:0]            sp;
  logic [NTW+2:0]            sn;

  logic [PTW-1:0]            l_pt, c_pt, r_pt, cl_pt;
  logic [NTW-1:0]            l_nt, c_nt, r_nt, cl_nt;
  logic [PTW+1:0]            cs_pt;
  logic [NTW+1:0]            cs_nt;
  logic [NXW-1:0]            cl_nx;
  logic                      seed;

`ifdef PHI_SLICE_XCNT_EN
  logic [NCH-1:0]            s1_x;
  logic [NXW-1:0]            h_nx [NETA];
  logic [NXW-1:0]            n_nx [NETA];
  logic [NXW+2:0]            sx;
  logic [NXW-1:0]            l_nx, c_nx, r_nx;
  logic [NXW+1:0]            cs_nx;
`else
  logic                      unused_bitx;
  assign unused_bitx = ^trk_bitx;
`endif

  assign busy   = (state != IDLE);
  assign filled = (state == SCAN);
  assign stall  = clu_valid && !clu_ready;

  always_comb begin
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = trk_valid[c] && (trk_phi[c*PHIW +: PHIW] == PHIW'(PHIBIN)) &&
               (trk_pt[c*PTW +: PTW] != '0) && (32'(trk_eta[c*ETAW +: ETAW]) < NETA);
    end
  end

  // All channels landing in the same bin are folded into one saturating update.
  always_comb begin
    sp      = '0;
    sn      = '0;
    bin_sat = '0;
    n_pt    = h_pt;
    n_nt    = h_nt;
`ifdef PHI_SLICE_XCNT_EN
    sx      = '0;
    n_nx    = h_nx;
`endif
    for (int b = 0; b < NETA; b++) begin
      sp = {3'b0, h_pt[b]};
      sn = {3'b0, h_nt[b]};
`ifdef PHI_SLICE_XCNT_EN
      sx = {3'b0, h_nx[b]};
`endif
      for (int c = 0; c < NCH; c++) begin
        if (s1_vld[c] && (32'(s1_eta[c]) == b)) begin
          sp = sp + {3'b0, s1_pt[c]};
          sn = sn + (NTW+3)'(1);
`ifdef PHI_SLICE_XCNT_EN
          sx = sx + (NXW+3)'(s1_x[c]);
`endif
        end
      end
      n_pt[b]    = (|sp[PTW+2:PTW]) ? '1 : sp[PTW-1:0];
      n_nt[b]    = (|sn[NTW+2:NTW]) ? '1 : sn[NTW-1:0];
      bin_sat[b] = (|sp[PTW+2:PTW]) || (|sn[NTW+2:NTW]);
`ifdef PHI_SLICE_XCNT_EN
      n_nx[b]    = (|sx[NXW+2:NXW]) ? '1 : sx[NXW-1:0];
      bin_sat[b] = bin_sat[b] || (|sx[NXW+2:NXW]);
`endif
    end
  end

  // Neighbourhood of the current scan index; out-of-range and consumed bins read as zero.
  always_comb begin
    l_pt = '0; c_pt = '0; r_pt = '0;
    l_nt = '0; c_nt = '0; r_nt = '0;
`ifdef PHI_SLICE_XCNT_EN
    l_nx = '0; c_nx = '0; r_nx = '0;
`endif
    for (int b = 0; b < NETA; b++) begin
      if (32'(idx) == b) begin
        c_pt = cons[b] ? '0 : h_pt[b];
        c_nt = cons[b] ? '0 : h_nt[b];
`ifdef PHI_SLICE_XCNT_EN
        c_nx = cons[b] ? '0 : h_nx[b];
`endif
      end
      if (32'(idx) == b + 1) begin
        l_pt = cons[b] ? '0 : h_pt[b];
        l_nt = cons[b] ? '0 : h_nt[b];
`ifdef PHI_SLICE_XCNT_EN
        l_nx = cons[b] ? '0 : h_nx[b];
`endif
      end
      if (32'(idx) + 1 == b) begin
        r_pt = cons[b] ? '0 : h_pt[b];
        r_nt = cons[b] ? '0 : h_nt[b];
`ifdef PHI_SLICE_XCNT_EN
        r_nx = cons[b] ? '0 : h_nx[b];
`endif
      end
    end
    seed  = (32'(idx) < NETA) && (c_pt != '0) && (c_pt >= l_pt) && (c_pt > r_pt);
    cs_pt = {2'b0, l_pt} + {2'b0, c_pt} + {2'b0, r_pt};
    cs_nt = {2'b0, l_nt} + {2'b0, c_nt} + {2'b0, r_nt};
    cl_pt = (|cs_pt[PTW+1:PTW]) ? '1 : cs_pt[PTW-1:0];
    cl_nt = (|cs_nt[NTW+1:NTW]) ? '1 : cs_nt[NTW-1:0];
`ifdef PHI_SLICE_XCNT_EN
    cs_nx = {2'b0, l_nx} + {2'b0, c_nx} + {2'b0, r_nx};
    cl_nx = (|cs_nx[NXW+1:NXW]) ? '1 : cs_nx[NXW-1:0];
`else
    cl_nx = '0;
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      dcnt      <= 1'b0;
      idx       <= '0;
      cons      <= '0;
      s1_vld    <= '0;
      s1_eta    <= '0;
      s1_pt     <= '0;
      clu_data  <= '0;
      clu_valid <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      for (int b = 0; b < NETA; b++) begin
        h_pt[b] <= '0;
        h_nt[b] <= '0;
`ifdef PHI_SLICE_XCNT_EN
        h_nx[b] <= '0;
`endif
      end
`ifdef PHI_SLICE_XCNT_EN
      s1_x      <= '0;
`endif
    end else if (start) begin
      state     <= FILL;
      dcnt      <= 1'b0;
      idx       <= '0;
      cons      <= '0;
      s1_vld    <= '0;
      clu_data  <= '0;
      clu_valid <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      for (int b = 0; b < NETA; b++) begin
        h_pt[b] <= '0;
        h_nt[b] <= '0;
`ifdef PHI_SLICE_XCNT_EN
        h_nx[b] <= '0;
`endif
      end
    end else begin
      done   <= 1'b0;
      s1_vld <= (state == FILL) ? acc : '0;
      for (int c = 0; c < NCH; c++) begin
        s1_eta[c] <= trk_eta[c*ETAW +: ETAW];
        s1_pt[c]  <= trk_pt[c*PTW +: PTW];
      end
`ifdef PHI_SLICE_XCNT_EN
      s1_x <= trk_bitx;
      h_nx <= n_nx;
`endif
      h_pt <= n_pt;
      h_nt <= n_nt;
      ovf  <= ovf | (|bin_sat);

      case (state)
        FILL: if (stop) state <= DRAIN;
        DRAIN: begin
          dcnt <= ~dcnt;
          if (dcnt) state <= SCAN;
        end
        SCAN: begin
          if (!stall) begin
            if (32'(idx) < NETA) begin
              clu_valid <= seed;
              if (seed) begin
                clu_data <= {cl_nt, cl_nx, ETAW'(idx), cl_pt};
                for (int b = 0; b < NETA; b++) begin
                  if (32'(idx) + 1 == b) cons[b] <= 1'b1;
                end
              end
              idx <= idx + IW'(1);
            end else begin
              clu_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/phi_slice_hist_v2.md
# phi_slice_hist_v2

Per-phi-slice eta histogrammer and L1 clusterer for the track jet finder, parametrised successor to the two-channel PHI block. It accepts NCH parallel track streams, accumulates pT, track count and special-track count into NETA eta bins for one phi slice, then scans the histogram once to emit 3-bin eta clusters over a valid/ready link to the jet merger. It sits between the track-conversion stage and the merge/L2 clustering stage, one instance per (z, phi) bin.

## Interface
- PHIBIN, 0: phi bin this instance accepts.
- NCH, 2: number of parallel track input channels (1–4).
- NETA, 24: eta bins (3–32).
- PTW, 9: pT width; NTW, 5: track-count width; NXW, 4: special-count width; PHIW, 5 / ETAW, 5: phi/eta index widths.
- clk  in  1  clock.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  pulse: clear histogram, begin fill.
- stop  in  1  pulse: end of track stream.
- trk_valid  in  NCH  per-channel track valid.
- trk_phi  in  NCH*PHIW  per-channel phi bin, channel c at [c*PHIW +: PHIW].
- trk_eta  in  NCH*ETAW  per-channel eta bin.
- trk_pt  in  NCH*PTW  per-channel pT.
- trk_bitx  in  NCH  per-channel special-track flag.
- clu_data  out  NTW+NXW+ETAW+PTW  {ntrx, xcount, eta, pt}.
- clu_valid  out  1  cluster word valid.
- clu_ready  in  1  downstream accepts word.
- busy  out  1  high in FILL/DRAIN/SCAN.
- filled  out  1  high in SCAN.
- done  out  1  one-cycle pulse at end of scan.
- ovf  out  1  sticky: any bin field saturated this event.

## Operation
- States IDLE → FILL → DRAIN → SCAN → IDLE.
- start (any state): histogram, ovf, scan index, output register cleared next edge; state → FILL. start has priority over stop and all other events.
- FILL: track on channel c accepted iff trk_valid[c], trk_phi==PHIBIN, trk_pt!=0, trk_eta<NETA; other tracks silently dropped.
- Accepted tracks registered (stage 1), bins updated (stage 2). All channels hitting the same bin in one cycle summed together: pT += Σpt, ntrx += count, xcount += count with bitx. Every field saturates at all-ones; saturation sets ovf.
- stop in FILL → DRAIN; tracks presented in the stop cycle still accepted. DRAIN lasts 2 cycles (pipeline flush) → SCAN. stop outside FILL ignored.
- SCAN: index i = 0..NETA-1, one bin per cycle when not stalled. E[-1]=E[NETA]=0; a bin flagged consumed reads as 0.
- Seed at i iff E[i]!=0, E[i]>=E[i-1], E[i]>E[i+1]. Cluster: pt=sat(E[i-1]+E[i]+E[i+1]), ntrx/xcount summed and saturated likewise, eta=i. Bin i+1 then flagged consumed.
- Output register loaded with the cluster; stall (index frozen) while clu_valid && !clu_ready. clu_data stable while stalled.
- After bin NETA-1 is evaluated and its cluster (if any) accepted: done pulses, state → IDLE. Histogram retained until next start.

## Timing
- Reset: state IDLE, histogram 0, clu_data 0, clu_valid 0, busy 0, filled 0, done 0, ovf 0.
- Track at inputs in cycle t is visible in histogram at t+2.
- stop at t → SCAN first evaluates bin 0 at t+3; cluster for bin i appears on clu_valid the cycle after bin i is evaluated.
- Unstalled scan: done asserted NETA+1 cycles after SCAN entry.
- rstb low mid-operation: immediate return to reset state; no partial cluster emitted.

## Configuration
- PHI_SLICE_XCNT_EN defined: xcount tracked per bin and reported in clu_data.
- Undefined: trk_bitx ignored, xcount storage not built, xcount field of clu_data tied 0; ovf ignores xcount.

## Test plan
- NCH=2, PHIBIN=3: one track pt=20 eta=5 phi=3, stop, clu_ready=1 → single cluster {ntrx=1, eta=5, pt=20}, done NETA+1 cycles after SCAN entry.
- Both channels same cycle, eta=7, pt=10 and 15, bitx=1/0 → cluster eta=7 pt=25 ntrx=2 xcount=1 (0 with macro off).
- Bins 4,5,6 = 10,30,10 and 8,9,10 = 5,5,9 → clusters eta=5 pt=50, eta=10 pt=14; bin 9 not re-seeded, bin 6 consumed.
- 3 tracks pt=511 same bin → pt=511, ovf=1; phi=4 or pt=0 tracks → no cluster, ovf=0.
- clu_ready held low 5 cycles during first cluster → clu_data stable, index frozen, no cluster lost; remaining clusters follow in order.
- start asserted mid-SCAN, then new single track → only new cluster emitted; rstb pulse mid-FILL → all outputs 0, state IDLE.
